led_afterglow: RTL and testbench

LED_AFTERGLOW -- requirements
Module: led_afterglow

---
 rtl/afterglow_pkg.sv | 38 +++
 rtl/afterglow_channel.sv | 65 ++++++
 rtl/led_afterglow.sv | 66 ++++++
 tb/tb_led_afterglow.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/afterglow_pkg.sv
// Shared definitions for the LED afterglow block.
//   LvlBitsDef : default per-channel brightness level width
//   LMAX       : full-brightness level for the default width
//   level_t    : level type for the default width
//   gamma_lut  : fixed gamma-correction table for the default width.
//                It is monotonic, maps 0 to 0 and maps LMAX to LMAX.
package afterglow_pkg;

    localparam int unsigned LvlBitsDef = 4;
    localparam int unsigned LMAX       = (1 << LvlBitsDef) - 1;

    typedef logic [LvlBitsDef-1:0] level_t;

    // Roughly quadratic perceptual curve.
    function automatic level_t gamma_lut(input level_t lvl);
        level_t g;
        unique case (lvl)
            4'd0:    g = 4'd0;
            4'd1:    g = 4'd1;
            4'd2:    g = 4'd1;
            4'd3:    g = 4'd1;
            4'd4:    g = 4'd2;
            4'd5:    g = 4'd2;
            4'd6:    g = 4'd3;
            4'd7:    g = 4'd4;
            4'd8:    g = 4'd5;
            4'd9:    g = 4'd6;
            4'd10:   g = 4'd7;
            4'd11:   g = 4'd8;
            4'd12:   g = 4'd10;
            4'd13:   g = 4'd11;
            4'd14:   g = 4'd13;
            default: g = 4'd15;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/afterglow_channel.sv
// One afterglow channel: brightness level register plus PWM compare.
// Build option: AFTERGLOW_GAMMA_EN selects the gamma-corrected level for the compare;
// otherwise the raw level is used (same latency either way).
// Ports:
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset
//   pattern_i  : raw pattern bit; 1 reloads the level to full brightness
//   tick_i     : one-cycle decay strobe from the shared prescaler
//   pwm_cnt_i  : shared free-running PWM counter (0..LMAX-1)
//   light_o    : registered PWM-dimmed drive
module afterglow_channel
    import afterglow_pkg::*;
#(
    parameter int unsigned LVL_BITS = LvlBitsDef
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                pattern_i,
    input  logic                tick_i,
    input  logic [LVL_BITS-1:0] pwm_cnt_i,
    output logic                light_o
);

    localparam logic [LVL_BITS-1:0] LvlMax = '1;

    logic [LVL_BITS-1:0] level_q, level_d;
    logic [LVL_BITS-1:0] eff_level;
    logic                light_q;

    // Reload wins over decay; decay saturates at zero.
    always_comb begin
        level_d = level_q;
        if (pattern_i) begin
            level_d = LvlMax;
        end else if (tick_i && (level_q != '0)) begin
            level_d = level_q - LVL_BITS'(1);
        end
    end

`ifdef AFTERGLOW_GAMMA_EN
    if (LVL_BITS == LvlBitsDef) begin : g_lut
        assign eff_level = gamma_lut(level_q);
    end else begin : g_sq
        // Non-default widths fall back to level^2 / LMAX, which keeps the end points.
        logic [2*LVL_BITS-1:0] sq;
        assign sq        = {{LVL_BITS{1'b0}}, level_q} * {{LVL_BITS{1'b0}}, level_q};
        assign eff_level = LVL_BITS'(sq / {{LVL_BITS{1'b0}}, LvlMax});
    end
`else
    assign eff_level = level_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= '0;
            light_q <= 1'b0;
        end else begin
            level_q <= level_d;
            light_q <= (eff_level > pwm_cnt_i);
        end
    end

    assign light_o = light_q;

endmodule

// File: rtl/led_afterglow.sv
// LED afterglow: each channel snaps to full brightness while its pattern bit is high
// and fades one step per decay tick once it drops, shown through a shared PWM.
// Build option: AFTERGLOW_GAMMA_EN (gamma-corrected brightness, see afterglow_channel).
// Ports:
//   clock      : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   pattern_in : raw LED pattern, one bit per channel
//   lights_out : registered PWM-dimmed LED drive
//   decay_tick : registered one-cycle strobe marking each decay step
module led_afterglow
    import afterglow_pkg::*;
#(
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned LVL_BITS  = LvlBitsDef,
    parameter int unsigned DECAY_DIV = 162500
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pattern_in,
    output logic [WIDTH-1:0] lights_out,
    output logic             decay_tick
);

    localparam int unsigned         CntW    = $clog2(DECAY_DIV);
    localparam logic [CntW-1:0]     CntLast = CntW'(DECAY_DIV - 1);
    localparam logic [LVL_BITS-1:0] PwmLast = LVL_BITS'((2 ** LVL_BITS) - 2);

    logic [CntW-1:0]     pre_cnt_q, pre_cnt_d;
    logic [LVL_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                tick_q, tick_d;

    always_comb begin
        pre_cnt_d = (pre_cnt_q == CntLast) ? '0 : pre_cnt_q + CntW'(1);
        tick_d    = (pre_cnt_q == CntLast);
        // PWM period is LMAX so that level LMAX is on for every count value.
        pwm_cnt_d = (pwm_cnt_q == PwmLast) ? '0 : pwm_cnt_q + LVL_BITS'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            tick_q    <= tick_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        afterglow_channel #(
            .LVL_BITS(LVL_BITS)
        ) u_ch (
            .clk_i    (clock),
            .rst_ni   (reset_n),
            .pattern_i(pattern_in[i]),
            .tick_i   (tick_q),
            .pwm_cnt_i(pwm_cnt_q),
            .light_o  (lights_out[i])
        );
    end

    assign decay_tick = tick_q;

endmodule

// File: tb/tb_led_afterglow.sv
// Scoreboard bench for led_afterglow (WIDTH=10, LVL_BITS=4, DECAY_DIV=4).
// Each stimulus cycle pushes the expected {lights_out, decay_tick} seen after that edge;
// a negedge monitor pops and compares. Directed spot checks use hand-computed constants.
module tb_led_afterglow;

    localparam int unsigned WIDTH     = 10;
    localparam int unsigned LVL_BITS  = 4;
    localparam int unsigned DECAY_DIV = 4;
    localparam int          LMAX      = 15;

    typedef struct packed {
        logic [WIDTH-1:0] lights;
        logic             tick;
    } exp_t;

    logic             clock;
    logic             reset_n;
    logic [WIDTH-1:0] pattern_in;
    logic [WIDTH-1:0] lights_out;
    logic             decay_tick;

    exp_t sb[$];
    int   total;
    int   bad;
    int   cyc;          // rising edges since reset release
    int   lvl[WIDTH];   // expected level per channel

    led_afterglow #(
        .WIDTH    (WIDTH),
        .LVL_BITS (LVL_BITS),
        .DECAY_DIV(DECAY_DIV)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .pattern_in(pattern_in),
        .lights_out(lights_out),
        .decay_tick(decay_tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // decay_tick value present after edge number c
    function automatic bit tick_at(input int c);
        return (c >= int'(DECAY_DIV)) && (c % int'(DECAY_DIV) == 0);
    endfunction

    function automatic int eff(input int l);
`ifdef AFTERGLOW_GAMMA_EN
        int tbl[16] = '{0, 1, 1, 1, 2, 2, 3, 4, 5, 6, 7, 8, 10, 11, 13, 15};
        return tbl[l];
`else
        return l;
`endif
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < int'(WIDTH); i++) lvl[i] = 0;
    endtask

    // Drive one cycle of pattern and queue the outputs expected after that edge.
    task automatic step(input logic [WIDTH-1:0] pat);
        exp_t e;
        bit   t;
        pattern_in = pat;
        @(posedge clock);
        t = tick_at(cyc);
        for (int i = 0; i < int'(WIDTH); i++) begin
            e.lights[i] = (eff(lvl[i]) > (cyc % LMAX));
            if (pat[i]) lvl[i] = LMAX;
            else if (t && lvl[i] > 0) lvl[i] = lvl[i] - 1;
        end
        cyc++;
        e.tick = tick_at(cyc);
        sb.push_back(e);
        #1;
    endtask

    task automatic run(input int n, input logic [WIDTH-1:0] pat);
        for (int k = 0; k < n; k++) step(pat);
    endtask

    always @(negedge clock) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("sb_lights", 32'(lights_out), 32'(e.lights));
            check("sb_tick", 32'(decay_tick), 32'(e.tick));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]       tick_seen;
        logic [WIDTH-1:0] sweep[12];
        int               duty[4];
        int               ones;
        bit               found;

        total = 0;
        bad   = 0;
        model_reset();

        // Reset held with every pattern bit high: outputs stay dark.
        reset_n    = 1'b0;
        pattern_in = '1;
        repeat (4) begin
            @(negedge clock);
            check("rst_lights", 32'(lights_out), 32'h0);
            check("rst_tick", 32'(decay_tick), 32'h0);
        end
        pattern_in = '0;
        @(negedge clock);
        reset_n = 1'b1;

        // Counting the release cycle as cycle 1, the first tick lands in cycle 5,
        // i.e. after the 4th rising edge.
        for (int k = 0; k < 5; k++) begin
            step('0);
            tick_seen[k] = decay_tick;
        end
        check("first_tick", 32'(tick_seen), 32'b01000);

        // Reload latency on bit 9: dark after the sampling edge, lit from the next one on.
        step(10'h200);
        check("reload_n1", 32'(lights_out[9]), 32'h0);
        for (int k = 0; k < 20; k++) begin
            step(10'h200);
            check("reload_held", 32'(lights_out[9]), 32'h1);
        end

        // Fade of bit 0 after a one-cycle pulse; fully dark after 15 ticks.
        step(10'h001);
        run(64, '0);
        for (int k = 0; k < 15; k++) begin
            step('0);
            check("fade_dark", 32'(lights_out[0]), 32'h0);
        end

        // Collision: reload bit 3 on the very edge that carries a tick while its level is 7.
        step(10'h008);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (lvl[3] == 7 && tick_at(cyc)) found = 1'b1;
            else step('0);
        end
        check("collision_align", 32'(found), 32'h1);
        step(10'h008);
        // Level 15 decays to no less than 11 over the next 15 cycles, so at least 8 lit
        // cycles even with gamma; a level of 6 could give at most 6.
        ones = 0;
        for (int k = 0; k < 15; k++) begin
            step('0);
            ones += int'(lights_out[3]);
        end
        check("collision_duty", 32'(ones >= 8), 32'h1);
        run(70, '0);

        // Sweep trail: each step held for two decay ticks.
        sweep = '{10'h200, 10'h300, 10'h180, 10'h0C0, 10'h060, 10'h030,
                  10'h018, 10'h00C, 10'h006, 10'h003, 10'h001, 10'h000};
        for (int s = 0; s < 12; s++) run(8, sweep[s]);
        for (int c = 0; c < 4; c++) duty[c] = 0;
        for (int k = 0; k < 15; k++) begin
            step('0);
            for (int c = 0; c < 4; c++) duty[c] += int'(lights_out[c]);
        end
`ifndef AFTERGLOW_GAMMA_EN
        for (int c = 0; c < 3; c++) check("sweep_trail", 32'(duty[c] > duty[c+1]), 32'h1);
`endif
        run(70, '0);

        // Reset mid-glow clears outputs at once and leaves nothing to resume.
        run(3, '1);
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_lights", 32'(lights_out), 32'h0);
        check("async_rst_tick", 32'(decay_tick), 32'h0);
        pattern_in = '0;
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        for (int k = 0; k < 20; k++) begin
            step('0);
            check("no_resume", 32'(lights_out), 32'h0);
        end

        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
